lfsr_pattern_gen: RTL and testbench

Parametrised Galois LFSR pattern generator driving LED/output pins in the TT user tile. The block has an internal clock-enable divider, so no derived clock leaves the block. It supports hold, divided free-run, single-step and full-speed modes, plus seed loading with all-zero lock-up protection. A period-wrap strobe flags when the sequence returns to its start value.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/lfsr_pattern_gen_if.sv | 23 ++
 rtl/tick_div.sv | 31 +++
 rtl/lfsr_pattern_gen.sv | 100 ++++++++++
 tb/tb_lfsr_pattern_gen.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared mode encodings and the Galois LFSR step function for the pattern generator.
package lfsr_pkg;

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_RUN_DIV  = 2'b01;
    localparam logic [1:0] MODE_STEP     = 2'b10;
    localparam logic [1:0] MODE_RUN_FAST = 2'b11;

    // Operates on a zero-extended state so one function serves every WIDTH up to 32.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        lfsr_next = state[0] ? ((state >> 1) ^ taps) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr_pattern_gen_if.sv
// Control/status bundle between the pattern generator and whatever drives its mode and seed.
interface lfsr_pattern_gen_if #(parameter int WIDTH = 8);

    logic [1:0]       mode;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             step_in;
    logic [WIDTH-1:0] lfsr_out;
    logic             adv;
    logic             wrap;
    logic             running;

    modport master (
        output mode, seed_load, seed, step_in,
        input  lfsr_out, adv, wrap, running
    );

    modport slave (
        input  mode, seed_load, seed, step_in,
        output lfsr_out, adv, wrap, running
    );

endinterface

// File: rtl/tick_div.sv
// Clock-enable divider: tick is high for one clk out of every DIV_MAX+1 while enabled.
module tick_div
    import lfsr_pkg::*;
#(
    parameter int DIV_MAX = 49_999_999,
    parameter int DIV_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_W-1:0] count;
    logic             at_max;

    assign at_max = (count == DIV_W'(DIV_MAX));
    assign tick   = en & at_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !en || at_max) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Galois LFSR pattern generator with hold / divided / single-step / full-speed advance,
// seed loading with all-zero protection, and a strobe when the start value recurs.
module lfsr_pattern_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_RST = 8'h01,
    parameter int               DIV_MAX  = 49_999_999,
    parameter int               DIV_W    = 26
) (
    input logic               clk,
    input logic               rst_n,
    lfsr_pattern_gen_if.slave bus
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_val;
    logic [1:0]       prev_mode;
    logic             step_s1;
    logic             step_s2;
    logic             step_s3;
    logic             step_rise;
    logic             tick;
    logic             div_clr;
    logic             advance;
    logic             adv_q;
    logic             wrap_q;

    // A zero result can only come from a non-maximal mask; substitute 1 to escape lock-up.
    assign shifted    = WIDTH'(lfsr_next(32'(lfsr_q), 32'(TAPS)));
    assign next_state = (shifted == '0) ? WIDTH'(1) : shifted;
    assign seed_val   = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

    assign step_rise = step_s2 & ~step_s3;
    assign div_clr   = bus.seed_load | (bus.mode != prev_mode);

    tick_div #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.mode == MODE_RUN_DIV),
        .clr   (div_clr),
        .tick  (tick)
    );

    always_comb begin
        advance = 1'b0;
        case (bus.mode)
            MODE_HOLD:     advance = 1'b0;
            MODE_RUN_DIV:  advance = tick;
            MODE_STEP:     advance = step_rise;
            MODE_RUN_FAST: advance = 1'b1;
            default:       advance = 1'b0;
        endcase
    end

    // Seed loading wins over an advance in the same cycle; the dropped advance raises no strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q    <= SEED_RST;
            start_q   <= SEED_RST;
            prev_mode <= MODE_HOLD;
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_s3   <= 1'b0;
            adv_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            prev_mode <= bus.mode;
            step_s1   <= bus.step_in;
            step_s2   <= step_s1;
            step_s3   <= step_s2;
            if (bus.seed_load) begin
                lfsr_q  <= seed_val;
                start_q <= seed_val;
                adv_q   <= 1'b0;
                wrap_q  <= 1'b0;
            end else if (advance) begin
                lfsr_q <= next_state;
                adv_q  <= 1'b1;
                wrap_q <= (next_state == start_q);
            end else begin
                adv_q  <= 1'b0;
                wrap_q <= 1'b0;
            end
        end
    end

    assign bus.lfsr_out = lfsr_q;
    assign bus.adv      = adv_q;
    assign bus.wrap     = wrap_q;
    assign bus.running  = (bus.mode == MODE_RUN_DIV) || (bus.mode == MODE_RUN_FAST);

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen with a short divider (DIV_MAX=9) so RUN_DIV timing is visible.
module tb_lfsr_pattern_gen;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lfsr_pattern_gen_if #(.WIDTH(8)) bus_if ();

    lfsr_pattern_gen #(
        .WIDTH    (8),
        .TAPS     (8'hB8),
        .SEED_RST (8'h01),
        .DIV_MAX  (9),
        .DIV_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Counts edges up to and including the one after which adv is seen; gives up at 60.
    task automatic wait_adv(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus_if.adv !== 1'b1 && n < 60);
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] v);
        logic [7:0] s;
        s = {1'b0, v[7:1]};
        model_next = v[0] ? (s ^ 8'hB8) : s;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         n;
        int         bad_seq;
        int         dup;
        int         bad_wrap;
        int         bad_adv;
        int         extra;
        logic [7:0] exp_v;
        bit         seen [256];
        logic [7:0] exp_fast [5];

        exp_fast[0] = 8'hB8;
        exp_fast[1] = 8'h5C;
        exp_fast[2] = 8'h2E;
        exp_fast[3] = 8'h17;
        exp_fast[4] = 8'hB3;

        bus_if.mode      = MODE_HOLD;
        bus_if.seed_load = 1'b0;
        bus_if.seed      = 8'h00;
        bus_if.step_in   = 1'b0;
        rst_n            = 1'b0;
        step();
        step();
        check_output("reset_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        check_output("reset_adv", 32'(bus_if.adv), 32'h0);
        check_output("reset_wrap", 32'(bus_if.wrap), 32'h0);
        check_output("reset_running", 32'(bus_if.running), 32'h0);
        rst_n = 1'b1;

        // Full-speed sequence from the reset seed
        bus_if.mode = MODE_RUN_FAST;
        #1;
        check_output("fast_running", 32'(bus_if.running), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("fast_lfsr", 32'(bus_if.lfsr_out), 32'(exp_fast[i]));
            check_output("fast_adv", 32'(bus_if.adv), 32'h1);
            check_output("fast_wrap", 32'(bus_if.wrap), 32'h0);
        end

        // Full period: 255 distinct states, wrap only on the last
        apply_reset();
        bad_seq  = 0;
        dup      = 0;
        bad_wrap = 0;
        bad_adv  = 0;
        exp_v    = 8'h01;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step();
            exp_v = model_next(exp_v);
            if (bus_if.lfsr_out !== exp_v) bad_seq++;
            if (bus_if.adv !== 1'b1) bad_adv++;
            if (i < 255) begin
                if (seen[bus_if.lfsr_out]) dup++;
                seen[bus_if.lfsr_out] = 1'b1;
                if (bus_if.wrap !== 1'b0) bad_wrap++;
            end
        end
        check_output("period_seq", 32'(bad_seq), 32'd0);
        check_output("period_adv", 32'(bad_adv), 32'd0);
        check_output("period_dups", 32'(dup), 32'd0);
        check_output("period_early_wrap", 32'(bad_wrap), 32'd0);
        check_output("period_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        check_output("period_wrap", 32'(bus_if.wrap), 32'h1);

        // Divided run: entry latency, steady period, re-entry after HOLD
        bus_if.mode = MODE_HOLD;
        apply_reset();
        bus_if.mode = MODE_RUN_DIV;
        wait_adv(n);
        check_output("div_entry_cycles", 32'(n), 32'd11);
        check_output("div_entry_lfsr", 32'(bus_if.lfsr_out), 32'hB8);
        wait_adv(n);
        check_output("div_period_cycles", 32'(n), 32'd10);
        check_output("div_period_lfsr", 32'(bus_if.lfsr_out), 32'h5C);
        bus_if.mode = MODE_HOLD;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus_if.adv !== 1'b0) extra++;
        end
        check_output("hold_no_adv", 32'(extra), 32'd0);
        check_output("hold_lfsr", 32'(bus_if.lfsr_out), 32'h5C);
        bus_if.mode = MODE_RUN_DIV;
        wait_adv(n);
        check_output("div_reentry_cycles", 32'(n), 32'd11);
        check_output("div_reentry_lfsr", 32'(bus_if.lfsr_out), 32'h2E);

        // Reset in the middle of a divided run
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        check_output("midrst_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        check_output("midrst_adv", 32'(bus_if.adv), 32'h0);
        check_output("midrst_wrap", 32'(bus_if.wrap), 32'h0);
        rst_n = 1'b1;
        wait_adv(n);
        check_output("midrst_release_cycles", 32'(n), 32'd11);
        check_output("midrst_release_lfsr", 32'(bus_if.lfsr_out), 32'hB8);

        // Single-step through the synchroniser and edge detector
        bus_if.mode = MODE_STEP;
        apply_reset();
        step();
        step();
        check_output("step_idle_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        check_output("step_running", 32'(bus_if.running), 32'h0);
        bus_if.step_in = 1'b1;
        step();
        check_output("step_lat1_adv", 32'(bus_if.adv), 32'h0);
        step();
        check_output("step_lat2_adv", 32'(bus_if.adv), 32'h0);
        check_output("step_lat2_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        step();
        check_output("step_first_adv", 32'(bus_if.adv), 32'h1);
        check_output("step_first_lfsr", 32'(bus_if.lfsr_out), 32'hB8);
        extra = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (bus_if.adv !== 1'b0) extra++;
        end
        check_output("step_held_no_adv", 32'(extra), 32'd0);
        check_output("step_held_lfsr", 32'(bus_if.lfsr_out), 32'hB8);
        bus_if.step_in = 1'b0;
        step();
        step();
        step();
        bus_if.step_in = 1'b1;
        step();
        step();
        check_output("step_second_pre_lfsr", 32'(bus_if.lfsr_out), 32'hB8);
        check_output("step_second_pre_adv", 32'(bus_if.adv), 32'h0);
        step();
        check_output("step_second_adv", 32'(bus_if.adv), 32'h1);
        check_output("step_second_lfsr", 32'(bus_if.lfsr_out), 32'h5C);
        step();
        check_output("step_second_post_adv", 32'(bus_if.adv), 32'h0);
        bus_if.step_in = 1'b0;

        // Seed loading: zero guard, priority over advance, wrap on the new start value
        bus_if.mode      = MODE_HOLD;
        bus_if.seed      = 8'h00;
        bus_if.seed_load = 1'b1;
        step();
        bus_if.seed_load = 1'b0;
        check_output("seed_zero_lfsr", 32'(bus_if.lfsr_out), 32'h01);
        check_output("seed_zero_adv", 32'(bus_if.adv), 32'h0);
        bus_if.mode = MODE_RUN_FAST;
        step();
        check_output("seed_fast_pre_lfsr", 32'(bus_if.lfsr_out), 32'hB8);
        bus_if.seed      = 8'h5C;
        bus_if.seed_load = 1'b1;
        step();
        bus_if.seed_load = 1'b0;
        check_output("seed_load_lfsr", 32'(bus_if.lfsr_out), 32'h5C);
        check_output("seed_load_adv", 32'(bus_if.adv), 32'h0);
        step();
        check_output("seed_next_lfsr", 32'(bus_if.lfsr_out), 32'h2E);
        check_output("seed_next_adv", 32'(bus_if.adv), 32'h1);
        bad_wrap = 0;
        for (int i = 2; i <= 255; i++) begin
            step();
            if (i < 255 && bus_if.wrap !== 1'b0) bad_wrap++;
        end
        check_output("seed_early_wrap", 32'(bad_wrap), 32'd0);
        check_output("seed_period_lfsr", 32'(bus_if.lfsr_out), 32'h5C);
        check_output("seed_period_wrap", 32'(bus_if.wrap), 32'h1);
        step();
        check_output("seed_after_wrap", 32'(bus_if.wrap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
